// File: rtl/knap_enumerator.sv
// Exhaustive selection-vector sequencer for the knapsack constraint checker.
// Steps cand through every selection, counting feasible ones and keeping the best.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; results of the last scan held
// S_SCAN | one candidate per cycle, checker verdict sampled each edge
// S_DONE | single-cycle completion pulse, then back to S_IDLE
module knap_enumerator #(
  parameter int N_ITEMS = 6,
  parameter int VAL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [N_ITEMS-1:0] cand,
  input  logic               chk_valid,
  input  logic [VAL_W-1:0]   chk_value,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_sel,
  output logic [VAL_W-1:0]   best_value,
  output logic [N_ITEMS:0]   valid_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [N_ITEMS-1:0] r_cand;
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic [N_ITEMS-1:0] r_best_sel;
  logic [VAL_W-1:0]   r_best_value;
  logic [N_ITEMS:0]   r_count;

  state_t             w_state_nxt;
  logic [N_ITEMS-1:0] w_cand_nxt;
  logic               w_found_nxt;
  logic [N_ITEMS-1:0] w_best_sel_nxt;
  logic [VAL_W-1:0]   w_best_value_nxt;
  logic [N_ITEMS:0]   w_count_nxt;
  logic               w_take;

  // Strict compare: on a tie the earlier (lower-numbered) selection is kept.
  assign w_take = chk_valid && (!r_found || (chk_value > r_best_value));

  always_comb begin
    w_state_nxt      = r_state;
    w_cand_nxt       = r_cand;
    w_found_nxt      = r_found;
    w_best_sel_nxt   = r_best_sel;
    w_best_value_nxt = r_best_value;
    w_count_nxt      = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt      = S_SCAN;
          w_cand_nxt       = '0;
          w_found_nxt      = 1'b0;
          w_best_sel_nxt   = '0;
          w_best_value_nxt = '0;
          w_count_nxt      = '0;
        end
      end
      S_SCAN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cand_nxt  = '0;
        end else begin
          if (chk_valid) begin
            w_count_nxt = r_count + (N_ITEMS+1)'(1);
          end
          if (w_take) begin
            w_found_nxt      = 1'b1;
            w_best_sel_nxt   = r_cand;
            w_best_value_nxt = chk_value;
          end
          // All-ones wraps to zero naturally on the increment.
          w_cand_nxt = r_cand + N_ITEMS'(1);
          if (&r_cand) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cand_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cand       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_best_sel   <= '0;
      r_best_value <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cand       <= w_cand_nxt;
      r_busy       <= (w_state_nxt == S_SCAN);
      r_done       <= (w_state_nxt == S_DONE);
      r_found      <= w_found_nxt;
      r_best_sel   <= w_best_sel_nxt;
      r_best_value <= w_best_value_nxt;
      r_count      <= w_count_nxt;
    end
  end

  assign cand        = r_cand;
  assign busy        = r_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign best_sel    = r_best_sel;
  assign best_value  = r_best_value;
  assign valid_count = r_count;

endmodule

// File: tb/tb_knap_enumerator.sv
// Bench for knap_enumerator: a behavioural checker (real item table, mocks and
// random tables) drives the verdict; results are compared to a reference scan.
module tb_knap_enumerator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] cand;
  logic       chk_valid;
  logic [5:0] chk_value;
  logic       busy;
  logic       done;
  logic       found;
  logic [5:0] best_sel;
  logic [5:0] best_value;
  logic [6:0] valid_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int mode   = 0;

  // Item table A..F: value, weight, volume, cost.
  localparam int IV[6] = '{8, 4, 4, 4, 3, 8};
  localparam int IW[6] = '{9, 4, 4, 4, 4, 2};
  localparam int IO[6] = '{1, 2, 2, 2, 2, 10};
  localparam int IC[6] = '{1, 2, 2, 2, 2, 1};

  bit         rnd_v[64];
  logic [5:0] rnd_val[64];

  logic       ref_found;
  logic [5:0] ref_sel;
  logic [5:0] ref_val;
  int         ref_cnt;

  knap_enumerator #(.N_ITEMS(6), .VAL_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cand(cand),
    .chk_valid(chk_valid), .chk_value(chk_value), .busy(busy), .done(done),
    .found(found), .best_sel(best_sel), .best_value(best_value),
    .valid_count(valid_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] chk_fn(input int m, input logic [5:0] c);
    int v, w, vo, co;
    v = 0; w = 0; vo = 0; co = 0;
    case (m)
      0: begin
        for (int i = 0; i < 6; i++) begin
          if (c[i]) begin
            v += IV[i]; w += IW[i]; vo += IO[i]; co += IC[i];
          end
        end
        return {(v >= 15 && w <= 16 && vo <= 10 && co <= 10), 6'(v)};
      end
      1: return {1'b1, c};
      2: return {1'b1, 6'd5};
      3: return 7'd0;
      default: return {rnd_v[c], rnd_val[c]};
    endcase
  endfunction

  assign {chk_valid, chk_value} = chk_fn(mode, cand);

  // Reference: count feasible, find the maximum value, then the first index holding it.
  task automatic ref_scan(input int limit);
    logic [6:0] r;
    int mx;
    mx = -1; ref_cnt = 0; ref_found = 1'b0; ref_sel = '0; ref_val = '0;
    for (int c = 0; c < limit; c++) begin
      r = chk_fn(mode, 6'(c));
      if (r[6]) begin
        ref_cnt++;
        if (int'(r[5:0]) > mx) mx = int'(r[5:0]);
      end
    end
    if (mx >= 0) begin
      ref_found = 1'b1;
      ref_val = 6'(mx);
      for (int c = limit - 1; c >= 0; c--) begin
        r = chk_fn(mode, 6'(c));
        if (r[6] && int'(r[5:0]) == mx) ref_sel = 6'(c);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic f, input logic [5:0] s,
                               input logic [5:0] v, input int cnt);
    check({tag, ".found"}, 32'(found), 32'(f));
    check({tag, ".best_sel"}, 32'(best_sel), 32'(s));
    check({tag, ".best_value"}, 32'(best_value), 32'(v));
    check({tag, ".valid_count"}, 32'(valid_count), 32'(cnt));
  endtask

  task automatic start_scan();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Full scan from the start pulse; verifies cand/busy sequence and done latency.
  task automatic run_full(input string tag);
    int n;
    bit seq_ok;
    start_scan();
    n = 0; seq_ok = 1'b1;
    while (!done && n < 200) begin
      if (cand !== 6'(n) || busy !== 1'b1) seq_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, ".seq"}, 32'(seq_ok), 32'd1);
    check({tag, ".latency"}, 32'(n), 32'd64);
    check({tag, ".done_busy"}, 32'({done, busy, cand}), 32'({1'b1, 1'b0, 6'd0}));
    @(negedge clk);
    check({tag, ".done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit no_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    #1;
    check("reset.outs", 32'({cand, busy, done, found}), 32'd0);
    check("reset.res", 32'({best_sel, best_value, valid_count}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Real checker: unique feasible selection B,C,D,E.
    mode = 0;
    run_full("real");
    check_results("real", 1'b1, 6'h1E, 6'd15, 1);
    repeat (3) @(negedge clk);
    check("real.hold", 32'({found, best_sel, valid_count}), 32'({1'b1, 6'h1E, 7'd1}));

    mode = 1;
    run_full("vcand");
    check_results("vcand", 1'b1, 6'h3F, 6'd63, 64);

    mode = 2;
    run_full("tie");
    check_results("tie", 1'b1, 6'h00, 6'd5, 64);

    mode = 3;
    run_full("none");
    check_results("none", 1'b0, 6'h00, 6'd0, 0);

    // Random tables checked against the reference scan.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        rnd_v[i]   = ($urandom_range(0, 3) == 0);
        rnd_val[i] = 6'($urandom_range(0, 63));
      end
      mode = 4;
      ref_scan(64);
      run_full("rand");
      check_results("rand", ref_found, ref_sel, ref_val, ref_cnt);
    end

    // Abort at cand=20 with a stray start at cand=10.
    for (int i = 0; i < 64; i++) begin
      rnd_v[i]   = ($urandom_range(0, 1) == 0);
      rnd_val[i] = 6'($urandom_range(0, 63));
    end
    mode = 4;
    start_scan();
    repeat (10) @(negedge clk);
    check("abort.c10", 32'(cand), 32'd10);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("abort.nostart", 32'({busy, cand}), 32'({1'b1, 6'd11}));
    repeat (9) @(negedge clk);
    check("abort.c20", 32'(cand), 32'd20);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort.idle", 32'({busy, done, cand}), 32'd0);
    ref_scan(20);
    check_results("abort", ref_found, ref_sel, ref_val, ref_cnt);
    no_done = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("abort.nodone", 32'(no_done), 32'd1);

    // Asynchronous reset mid-scan, then a fresh real scan.
    mode = 0;
    start_scan();
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid.outs", 32'({cand, busy, done, found}), 32'd0);
    check("rstmid.res", 32'({best_sel, best_value, valid_count}), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid.quiet", 32'({busy, done, cand}), 32'd0);
    run_full("after_rst");
    check_results("after_rst", 1'b1, 6'h1E, 6'd15, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
